// File: rtl/cpu24_pkg.sv
// Shared constants and FSM encoding for the 24-bit CPU memory-side blocks.
package cpu24_pkg;
  localparam int WORD_W         = 24;
  localparam int BYTES_PER_WORD = 3;
  localparam int ADDR_W         = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;
endpackage

// File: rtl/data_mem_responder_byte_store.sv
// Byte-addressed store with a synchronous little-endian 3-byte write and read.
module byte_store
  import cpu24_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int AW          = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);
  logic [7:0]        r_mem [DEPTH_BYTES];
  logic [WORD_W-1:0] r_rdata;
  logic [AW-1:0]     w_a1, w_a2;

  // Callers only enable an access when base+2 is inside the array.
  assign w_a1 = i_addr + AW'(1);
  assign w_a2 = i_addr + AW'(2);

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata[7:0];
      r_mem[w_a1]   <= i_wdata[15:8];
      r_mem[w_a2]   <= i_wdata[23:16];
    end
    if (i_re)
      r_rdata <= {r_mem[w_a2], r_mem[w_a1], r_mem[i_addr]};
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: one outstanding load/store, programmable wait states,
// range-checked 3-byte little-endian access, valid/ready on request and response.
module data_mem_responder
  import cpu24_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [WORD_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [WORD_W-1:0] o_resp_rdata,
  output logic              o_resp_err
);
  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [ADDR_W:0] LAST_BASE = (ADDR_W+1)'(DEPTH_BYTES - BYTES_PER_WORD);

  state_e            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write, r_err, r_load_ok;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] w_store_rdata;
  logic              w_accept, w_in_range, w_we, w_re, w_in_access;

  assign w_accept    = i_req_valid & o_req_ready;
  // 25-bit compare so addresses near 2^24 cannot wrap into range.
  assign w_in_range  = {1'b0, r_addr} <= LAST_BASE;
  assign w_in_access = (r_state == ST_ACCESS);
  assign w_we        = w_in_access & r_write & w_in_range & ~i_rst;
  assign w_re        = w_in_access & ~r_write & w_in_range;

  byte_store #(.DEPTH_BYTES(DEPTH_BYTES), .AW(AW)) u_store (
    .i_clk  (i_clk),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_addr (r_addr[AW-1:0]),
    .i_wdata(r_wdata),
    .o_rdata(w_store_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (r_cnt == CNT_W'(1)) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   if (i_resp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready  = (r_state == ST_IDLE) & ~i_rst;
    o_resp_valid = (r_state == ST_RESP);
    o_resp_err   = r_err;
    o_resp_rdata = r_load_ok ? w_store_rdata : '0;
  end

  // Load data stays in the store's read register; r_load_ok gates it onto the port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_load_ok <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= i_req_write;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_cnt   <= CNT_W'(WAIT_CYCLES);
      end
      if (r_state == ST_WAIT) r_cnt <= r_cnt - CNT_W'(1);
      if (w_in_access) begin
        r_err     <= ~w_in_range;
        r_load_ok <= ~r_write & w_in_range;
      end
      if ((r_state == ST_RESP) && i_resp_ready) begin
        r_err     <= 1'b0;
        r_load_ok <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table, corner sequences, random ops vs a byte-array model.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam logic [23:0] LAST = 24'(DEPTH - 3);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with two wait states
  logic        rst, rq_v, rq_w, rs_r;
  logic [23:0] rq_a, rq_d;
  logic        rq_rdy, rs_v, rs_e;
  logic [23:0] rs_d;

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(2), .CNT_W(8)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(rq_v), .o_req_ready(rq_rdy),
    .i_req_write(rq_w), .i_req_addr(rq_a), .i_req_wdata(rq_d),
    .o_resp_valid(rs_v), .i_resp_ready(rs_r), .o_resp_rdata(rs_d), .o_resp_err(rs_e)
  );

  // DUT with zero wait states
  logic        z_rst, z_v, z_w, z_rr;
  logic [23:0] z_a, z_d;
  logic        z_rdy, z_rv, z_re;
  logic [23:0] z_rd;

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0), .CNT_W(8)) u_dut0 (
    .i_clk(clk), .i_rst(z_rst), .i_req_valid(z_v), .o_req_ready(z_rdy),
    .i_req_write(z_w), .i_req_addr(z_a), .i_req_wdata(z_d),
    .o_resp_valid(z_rv), .i_resp_ready(z_rr), .o_resp_rdata(z_rd), .o_resp_err(z_re)
  );

  int nerr = 0, nchk = 0;
  logic [7:0] mdl [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a word is three consecutive bytes, LSB at the base address.
  task automatic mdl_access(input logic wr, input logic [23:0] a, input logic [23:0] d,
                            output logic [23:0] rd, output logic er);
    logic [7:0] ia;
    ia = a[7:0];
    rd = '0;
    er = 1'b0;
    if (a > LAST) er = 1'b1;
    else if (wr) begin
      mdl[ia]        = d[7:0];
      mdl[ia + 8'd1] = d[15:8];
      mdl[ia + 8'd2] = d[23:16];
    end else rd = {mdl[ia + 8'd2], mdl[ia + 8'd1], mdl[ia]};
  endtask

  task automatic txn(input string nm, input logic wr, input logic [23:0] a, input logic [23:0] d,
                     input int hold, output logic [23:0] rd, output logic er);
    int n;
    chk({nm, ".ready"}, 32'(rq_rdy), 1);
    rq_v = 1'b1; rq_w = wr; rq_a = a; rq_d = d; rs_r = 1'b0;
    @(posedge clk); #1;
    rq_v = 1'b0;
    n = 1;
    while (!rs_v && n < 30) begin @(posedge clk); #1; n++; end
    chk({nm, ".latency"}, 32'(n), 4);
    rd = rs_d;
    er = rs_e;
    for (int i = 0; i < hold; i++) begin
      rq_v = 1'b1; rq_a = ~a; rq_w = ~wr;
      @(posedge clk); #1;
      chk({nm, ".hold_valid"}, 32'(rs_v), 1);
      chk({nm, ".hold_rdata"}, 32'(rs_d), 32'(rd));
      chk({nm, ".hold_ready"}, 32'(rq_rdy), 0);
    end
    rq_v = 1'b0; rs_r = 1'b1;
    @(posedge clk); #1;
    rs_r = 1'b0;
    chk({nm, ".done_valid"}, 32'(rs_v), 0);
    chk({nm, ".done_rdata"}, 32'(rs_d), 0);
    chk({nm, ".done_err"},   32'(rs_e), 0);
    chk({nm, ".done_ready"}, 32'(rq_rdy), 1);
  endtask

  typedef struct {
    logic        wr;
    logic [23:0] a;
    logic [23:0] d;
    logic [23:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [23:0] rd, md;
    logic er, me;
    int cnt;

    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    rst = 1'b1; rq_v = 0; rq_w = 0; rq_a = 0; rq_d = 0; rs_r = 0;
    z_rst = 1'b1; z_v = 0; z_w = 0; z_a = 0; z_d = 0; z_rr = 0;

    vt[0]  = '{1'b1, 24'h000010, 24'hABCDEF, 24'h000000, 1'b0};
    vt[1]  = '{1'b0, 24'h000010, 24'h000000, 24'hABCDEF, 1'b0};
    vt[2]  = '{1'b0, 24'h000011, 24'h000000, 24'h00ABCD, 1'b0};
    vt[3]  = '{1'b0, 24'h00000F, 24'h000000, 24'hCDEF00, 1'b0};
    vt[4]  = '{1'b1, 24'd253,    24'h5A5A5A, 24'h000000, 1'b0};
    vt[5]  = '{1'b1, 24'd254,    24'h111111, 24'h000000, 1'b1};
    vt[6]  = '{1'b0, 24'd253,    24'h000000, 24'h5A5A5A, 1'b0};
    vt[7]  = '{1'b0, 24'd254,    24'h000000, 24'h000000, 1'b1};
    vt[8]  = '{1'b0, 24'hFFFFFF, 24'h000000, 24'h000000, 1'b1};
    vt[9]  = '{1'b1, 24'hFFFFFE, 24'h222222, 24'h000000, 1'b1};
    vt[10] = '{1'b0, 24'h000000, 24'h000000, 24'h000000, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(rq_rdy), 0);
    chk("rst.valid", 32'(rs_v), 0);
    chk("rst.rdata", 32'(rs_d), 0);
    chk("rst.err",   32'(rs_e), 0);
    rst = 1'b0;
    #1;
    chk("rst.ready_after", 32'(rq_rdy), 1);

    for (int i = 0; i < 11; i++) begin
      txn($sformatf("vec%0d", i), vt[i].wr, vt[i].a, vt[i].d, 0, rd, er);
      mdl_access(vt[i].wr, vt[i].a, vt[i].d, md, me);
      chk($sformatf("vec%0d.rdata", i), 32'(rd), 32'(vt[i].exp_d));
      chk($sformatf("vec%0d.err", i),   32'(er), 32'(vt[i].exp_e));
    end

    // response held for 5 cycles while a new request is pending
    txn("hold", 1'b0, 24'h000010, 24'h0, 5, rd, er);
    chk("hold.rdata", 32'(rd), 32'hABCDEF);
    repeat (2) begin @(posedge clk); #1; chk("hold.no_extra", 32'(rs_v), 0); end

    // reset on the edge that closes ACCESS suppresses the store
    txn("pre", 1'b1, 24'h000020, 24'h123456, 0, rd, er);
    mdl_access(1'b1, 24'h000020, 24'h123456, md, me);
    rq_v = 1'b1; rq_w = 1'b1; rq_a = 24'h000020; rq_d = 24'h777777;
    @(posedge clk); #1;
    rq_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstacc.valid", 32'(rs_v), 0);
    chk("rstacc.rdata", 32'(rs_d), 0);
    chk("rstacc.err",   32'(rs_e), 0);
    chk("rstacc.ready", 32'(rq_rdy), 0);
    rst = 1'b0;
    #1;
    chk("rstacc.ready_after", 32'(rq_rdy), 1);
    txn("rstacc.load", 1'b0, 24'h000020, 24'h0, 0, rd, er);
    chk("rstacc.data", 32'(rd), 32'h123456);

    // reset during WAIT drops the request
    rq_v = 1'b1; rq_w = 1'b0; rq_a = 24'h000010;
    @(posedge clk); #1;
    rq_v = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin @(posedge clk); #1; if (rs_v) cnt++; end
    chk("rstwait.no_resp", 32'(cnt), 0);
    txn("rstwait.next", 1'b0, 24'h000010, 24'h0, 0, rd, er);
    chk("rstwait.data", 32'(rd), 32'hABCDEF);
    chk("rstwait.err",  32'(er), 0);

    // random traffic against the model
    for (int i = 0; i < 40; i++) begin
      logic        w;
      logic [23:0] a, d;
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1:    a = 24'($urandom_range(0, 40));
        2:       a = 24'($urandom_range(240, 260));
        default: a = 24'($urandom);
      endcase
      d = 24'($urandom);
      mdl_access(w, a, d, md, me);
      txn($sformatf("rnd%0d", i), w, a, d, 0, rd, er);
      chk($sformatf("rnd%0d.rdata", i), 32'(rd), 32'(md));
      chk($sformatf("rnd%0d.err", i),   32'(er), 32'(me));
    end

    // zero wait states, request and response ready tied high
    z_rst = 1'b0;
    #1;
    chk("z.ready0", 32'(z_rdy), 1);
    z_v = 1'b1; z_w = 1'b1; z_a = 24'd7; z_d = 24'h3C5A96; z_rr = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(posedge clk); #1;
      if (j == 0) z_w = 1'b0;
      chk($sformatf("z%0d.valid", j), 32'(z_rv),  32'((j % 3) == 1));
      chk($sformatf("z%0d.ready", j), 32'(z_rdy), 32'((j % 3) == 2));
      if ((j % 3) == 1) begin
        chk($sformatf("z%0d.rdata", j), 32'(z_rd), (j == 1) ? 32'h0 : 32'h3C5A96);
        chk($sformatf("z%0d.err", j),   32'(z_re), 0);
      end
    end
    z_v = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
